// File: rtl/ps2_keyboard_rx_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
// The producer side drives the FIFO head fields and valid. The consumer side drives ready.
interface ps2_keyboard_rx_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_ext,
        output key_break,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_ext,
        input  key_break,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver that runs entirely in the system clock domain.
// ps2c and ps2d are synchronised. ps2c is then glitch-filtered, and its falling edge becomes
// a strobe that clocks the frame FSM. Accepted bytes are decoded for E0/F0 prefixes into
// make/break events. Those events are queued in a first-word-fall-through FIFO.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int MODE        = 0
) (
    input  logic                              clk,
    input  logic                              clr_n,
    input  logic                              ps2c,
    input  logic                              ps2d,
    ps2_keyboard_rx_if.master                 key_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              parity_err,
    output logic                              frame_err
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [1:0]    MODE_C   = 2'(MODE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Frame is good when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

    logic          ps2c_meta_r, ps2c_sync_r, ps2d_meta_r, ps2d_sync_r;
    logic          ps2c_filt_r;
    logic [FW-1:0] filt_cnt_r;
    logic          strobe_s;

    state_t        state_r, state_nx_s;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          parity_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_hit_s, shift_en_s, par_cap_s, accept_s, perr_s, ferr_s, bit_clr_s;
    logic          rx_done_r;
    logic [7:0]    rx_byte_r;
    logic          parity_err_r, frame_err_r;

    logic          ext_pend_r, brk_pend_r;
    logic          rec_vld_r;
    logic [8:0]    rec_key_r;
    logic          push_s, set_ext_s, set_brk_s, pend_clr_s, rec_set_s, rec_clr_s;
    logic [9:0]    evt_s;

    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          pop_s, full_s, wr_s;

    // Two-flop synchronisers for both PS/2 lines; idle bus level is high.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ps2c_meta_r <= 1'b1;
            ps2c_sync_r <= 1'b1;
            ps2d_meta_r <= 1'b1;
            ps2d_sync_r <= 1'b1;
        end else begin
            ps2c_meta_r <= ps2c;
            ps2c_sync_r <= ps2c_meta_r;
            ps2d_meta_r <= ps2d;
            ps2d_sync_r <= ps2d_meta_r;
        end
    end

    // The filtered clock follows the synced clock only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ps2c_filt_r <= 1'b1;
            filt_cnt_r  <= {FW{1'b0}};
        end else if (ps2c_sync_r == ps2c_filt_r) begin
            filt_cnt_r  <= {FW{1'b0}};
        end else if (filt_cnt_r == FILT_MAX) begin
            ps2c_filt_r <= ps2c_sync_r;
            filt_cnt_r  <= {FW{1'b0}};
        end else begin
            filt_cnt_r  <= filt_cnt_r + FW'(1);
        end
    end

    // One-cycle strobe in the cycle where the filtered clock is about to fall.
    assign strobe_s = ps2c_filt_r && !ps2c_sync_r && (filt_cnt_r == FILT_MAX);

    // Frame FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame FSM next state and per-strobe actions; a timeout overrides everything.
    always_comb begin
        state_nx_s = state_r;
        shift_en_s = 1'b0;
        par_cap_s  = 1'b0;
        accept_s   = 1'b0;
        perr_s     = 1'b0;
        ferr_s     = 1'b0;
        bit_clr_s  = 1'b0;
        tmo_hit_s  = (state_r != ST_IDLE) && (tmo_cnt_r == TMO_MAX) && !strobe_s;
        if (tmo_hit_s) begin
            state_nx_s = ST_IDLE;
            ferr_s     = 1'b1;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!ps2d_sync_r) begin
                        state_nx_s = ST_DATA;
                        bit_clr_s  = 1'b1;
                    end else begin
                        ferr_s     = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = ST_PARITY;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_cap_s  = 1'b1;
                    state_nx_s = ST_STOP;
                end
                ST_STOP: begin
                    state_nx_s = ST_IDLE;
                    if (!odd_parity_ok(shift_r, parity_r)) begin
                        perr_s   = 1'b1;
                    end else if (!ps2d_sync_r) begin
                        ferr_s   = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame datapath: bit counter, shifter, parity capture, timeout counter, result pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            parity_r     <= 1'b0;
            tmo_cnt_r    <= {TW{1'b0}};
            rx_done_r    <= 1'b0;
            rx_byte_r    <= 8'd0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {ps2d_sync_r, shift_r[7:1]};
            end
            if (par_cap_s) begin
                parity_r <= ps2d_sync_r;
            end
            if ((state_r == ST_IDLE) || strobe_s || tmo_hit_s) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            rx_done_r <= accept_s;
            if (accept_s) begin
                rx_byte_r <= shift_r;
            end
            parity_err_r <= perr_s;
            frame_err_r  <= ferr_s;
        end
    end

    assign evt_s = {ext_pend_r, brk_pend_r, rx_byte_r};

    // Prefix decoding and the per-mode decision of whether an event is queued.
    always_comb begin
        push_s     = 1'b0;
        set_ext_s  = 1'b0;
        set_brk_s  = 1'b0;
        pend_clr_s = 1'b0;
        rec_set_s  = 1'b0;
        rec_clr_s  = 1'b0;
        if (rx_done_r) begin
            if (rx_byte_r == 8'hE0) begin
                set_ext_s = 1'b1;
            end else if (rx_byte_r == 8'hF0) begin
                set_brk_s = 1'b1;
            end else if ((rx_byte_r == 8'h00) || (rx_byte_r == 8'hFF)) begin
                pend_clr_s = 1'b1;
            end else begin
                pend_clr_s = 1'b1;
                case (MODE_C)
                    2'd0: begin
                        push_s = brk_pend_r;
                    end
                    2'd1: begin
                        if (brk_pend_r) begin
                            push_s    = 1'b1;
                            rec_clr_s = 1'b1;
                        end else if (!rec_vld_r || (rec_key_r != {ext_pend_r, rx_byte_r})) begin
                            push_s    = 1'b1;
                            rec_set_s = 1'b1;
                        end else begin
                            push_s    = 1'b0;
                        end
                    end
                    default: begin
                        push_s = 1'b1;
                    end
                endcase
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Pending prefixes and the last-queued-make record used to suppress typematic repeats.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
            rec_vld_r  <= 1'b0;
            rec_key_r  <= 9'd0;
        end else begin
            if (set_ext_s) begin
                ext_pend_r <= 1'b1;
            end else if (pend_clr_s) begin
                ext_pend_r <= 1'b0;
            end
            if (set_brk_s) begin
                brk_pend_r <= 1'b1;
            end else if (pend_clr_s) begin
                brk_pend_r <= 1'b0;
            end
            if (rec_set_s) begin
                rec_vld_r <= 1'b1;
                rec_key_r <= {ext_pend_r, rx_byte_r};
            end else if (rec_clr_s) begin
                rec_vld_r <= 1'b0;
            end
        end
    end

    assign pop_s  = key_if.key_valid && key_if.key_ready;
    assign full_s = (count_r == DEPTH_C);
    assign wr_s   = push_s && (!full_s || pop_s);

    // Event storage. A write into a full FIFO is allowed only when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= evt_s;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign key_if.key_valid = (count_r != {CW{1'b0}});
    assign key_if.key_ext   = mem_r[rd_ptr_r][9];
    assign key_if.key_break = mem_r[rd_ptr_r][8];
    assign key_if.key_code  = mem_r[rd_ptr_r][7:0];
    assign fifo_count       = count_r;
    assign overflow         = overflow_r;
    assign parity_err       = parity_err_r;
    assign frame_err        = frame_err_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx. Three receivers (MODE 0, 1 and 2) share the same PS/2 lines.
// Each phase drives a hand-written frame sequence. Queued events are then popped and
// compared against a table of expected {ext, brk, code} records.
module tb_ps2_keyboard_rx;

    logic       clk;
    logic       clr_n;
    logic       ps2c;
    logic       ps2d;
    logic [2:0] rdy;

    logic [9:0] head  [3];
    logic       valid [3];
    logic [3:0] cnt   [3];
    logic       ovf   [3];
    logic       perr  [3];
    logic       ferr  [3];

    int perr_n [3];
    int ferr_n [3];
    int total;
    int passed;

    typedef struct {
        int         phase;
        int         inst;
        logic [9:0] evt;
    } exp_t;

    exp_t tbl [$];
    int   exp_perr [8];
    int   exp_ferr [8];

    ps2_keyboard_rx_if if0 ();
    ps2_keyboard_rx_if if1 ();
    ps2_keyboard_rx_if if2 ();

    assign if0.key_ready = rdy[0];
    assign if1.key_ready = rdy[1];
    assign if2.key_ready = rdy[2];
    assign head[0]  = {if0.key_ext, if0.key_break, if0.key_code};
    assign head[1]  = {if1.key_ext, if1.key_break, if1.key_code};
    assign head[2]  = {if2.key_ext, if2.key_break, if2.key_code};
    assign valid[0] = if0.key_valid;
    assign valid[1] = if1.key_valid;
    assign valid[2] = if2.key_valid;

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(1000), .FIFO_DEPTH(8), .MODE(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .ps2c(ps2c), .ps2d(ps2d), .key_if(if0),
        .fifo_count(cnt[0]), .overflow(ovf[0]), .parity_err(perr[0]), .frame_err(ferr[0]));
    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(1000), .FIFO_DEPTH(8), .MODE(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .ps2c(ps2c), .ps2d(ps2d), .key_if(if1),
        .fifo_count(cnt[1]), .overflow(ovf[1]), .parity_err(perr[1]), .frame_err(ferr[1]));
    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(1000), .FIFO_DEPTH(8), .MODE(2)) dut2 (
        .clk(clk), .clr_n(clr_n), .ps2c(ps2c), .ps2d(ps2d), .key_if(if2),
        .fifo_count(cnt[2]), .overflow(ovf[2]), .parity_err(perr[2]), .frame_err(ferr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count error pulses per receiver, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (perr[i]) perr_n[i] <= perr_n[i] + 1;
            if (ferr[i]) ferr_n[i] <= ferr_n[i] + 1;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int inst, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic add_exp(input int ph, input int inst, input logic [9:0] evt);
        exp_t e;
        e.phase = ph;
        e.inst  = inst;
        e.evt   = evt;
        tbl.push_back(e);
    endtask

    // One PS/2 bit: data set while clock high, then a low pulse; optional short clock glitch.
    task automatic send_bit(input logic b, input logic glitch);
        ps2d = b;
        if (glitch) begin
            wait_cyc(3);
            ps2c = 1'b0;
            wait_cyc(2);
            ps2c = 1'b1;
            wait_cyc(5);
        end else begin
            wait_cyc(10);
        end
        ps2c = 1'b0;
        wait_cyc(20);
        ps2c = 1'b1;
        wait_cyc(10);
    endtask

    // First nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            send_bit(f[k], glitch && (k == 3));
        end
        ps2d = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        wait_cyc(3);
        clr_n = 1'b1;
        wait_cyc(3);
    endtask

    task automatic pop_check(input int i, input logic [9:0] evt);
        int k;
        k = 0;
        while (!valid[i] && k < 200) begin
            wait_cyc(1);
            k++;
        end
        check("head_valid", i, int'(valid[i]), 1);
        check("head_event", i, int'(head[i]), int'(evt));
        rdy[i] = 1'b1;
        wait_cyc(1);
        rdy[i] = 1'b0;
    endtask

    task automatic run_phase(input int ph);
        case (ph)
            1: begin send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); end
            2: begin send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C); end
            3: begin send_frame(8'h1C, 1'b1, 1'b0, 11); send(8'hF0); send(8'h1C); end
            4: begin
                send_frame(8'h1C, 1'b0, 1'b0, 6);
                wait_cyc(1200);
                check("tmo_ferr", 2, ferr_n[2], 1);
                send(8'h1C);
            end
            5: begin send_frame(8'h2A, 1'b0, 1'b1, 11); end
            6: begin
                for (int c = 0; c < 9; c++) send(8'h11 + 8'(c));
            end
            7: begin
                send(8'h1C);
                wait_cyc(20);
                check("pre_rst_cnt", 2, int'(cnt[2]), 1);
                do_reset();
                for (int i = 0; i < 3; i++) begin
                    check("rst_cnt", i, int'(cnt[i]), 0);
                    check("rst_ovf", i, int'(ovf[i]), 0);
                end
                send_frame(8'h3B, 1'b0, 1'b0, 3);
                do_reset();
                send(8'h1C);
            end
            default: wait_cyc(1);
        endcase
    endtask

    initial begin
        int bp [3];
        int bf [3];
        int n;
        total  = 0;
        passed = 0;
        for (int i = 0; i < 3; i++) begin
            perr_n[i] = 0;
            ferr_n[i] = 0;
        end
        for (int p = 0; p < 8; p++) begin
            exp_perr[p] = 0;
            exp_ferr[p] = 0;
        end
        exp_perr[3] = 1;
        exp_ferr[4] = 1;

        // Expected events {ext, brk, code} per phase and receiver.
        add_exp(1, 0, 10'h11C);
        add_exp(1, 1, 10'h01C); add_exp(1, 1, 10'h11C);
        add_exp(1, 2, 10'h01C); add_exp(1, 2, 10'h01C); add_exp(1, 2, 10'h01C); add_exp(1, 2, 10'h11C);
        add_exp(2, 0, 10'h375);
        add_exp(2, 1, 10'h375); add_exp(2, 1, 10'h01C);
        add_exp(2, 2, 10'h375); add_exp(2, 2, 10'h01C);
        add_exp(3, 0, 10'h11C); add_exp(3, 1, 10'h11C); add_exp(3, 2, 10'h11C);
        add_exp(4, 1, 10'h01C); add_exp(4, 2, 10'h01C);
        add_exp(5, 1, 10'h02A); add_exp(5, 2, 10'h02A);
        for (int c = 0; c < 8; c++) begin
            add_exp(6, 1, 10'h011 + 10'(c));
            add_exp(6, 2, 10'h011 + 10'(c));
        end
        add_exp(7, 1, 10'h01C); add_exp(7, 2, 10'h01C);

        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rdy   = 3'b000;
        clr_n = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < 3; i++) begin
            check("reset_valid", i, int'(valid[i]), 0);
            check("reset_count", i, int'(cnt[i]), 0);
            check("reset_ovf",   i, int'(ovf[i]), 0);
            check("reset_head",  i, int'(head[i]), 0);
        end
        clr_n = 1'b1;
        wait_cyc(5);

        for (int ph = 1; ph <= 7; ph++) begin
            for (int i = 0; i < 3; i++) begin
                bp[i] = perr_n[i];
                bf[i] = ferr_n[i];
            end
            run_phase(ph);
            wait_cyc(60);
            for (int i = 0; i < 3; i++) begin
                n = 0;
                foreach (tbl[j]) if (tbl[j].phase == ph && tbl[j].inst == i) n++;
                check($sformatf("p%0d_count", ph), i, int'(cnt[i]), n);
                check($sformatf("p%0d_ovf", ph), i, int'(ovf[i]), (ph == 6 && i != 0) ? 1 : 0);
                check($sformatf("p%0d_perr", ph), i, perr_n[i] - bp[i], exp_perr[ph]);
                check($sformatf("p%0d_ferr", ph), i, ferr_n[i] - bf[i], exp_ferr[ph]);
                foreach (tbl[j]) begin
                    if (tbl[j].phase == ph && tbl[j].inst == i) pop_check(i, tbl[j].evt);
                end
                wait_cyc(2);
                check($sformatf("p%0d_empty", ph), i, int'(valid[i]), 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
